// File: rtl/sipo8_capture.sv
// MSB-first serial-in/parallel-out byte assembler with a one-entry valid/ready holding register.
// Optional SIPO_INVERT_EN: shift in ~serIn to convert active-low video data.
module sipo8_capture #(
    parameter int BYTES_PER_LINE = 64,
    parameter int IDX_W          = $clog2(BYTES_PER_LINE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sampleEn,
    input  logic             serIn,
    input  logic             lineStart,
    input  logic             outReady,
    output logic [7:0]       parOut,
    output logic             outValid,
    output logic [IDX_W-1:0] byteIdx,
    output logic             lineDone,
    output logic             overflow
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(BYTES_PER_LINE - 1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [6:0]       r_shift;
    logic [2:0]       r_bitCnt;
    logic [IDX_W-1:0] r_pos;
    logic [7:0]       r_parOut;
    logic             r_outValid;
    logic [IDX_W-1:0] r_byteIdx;
    logic             r_lineDone;
    logic             r_overflow;

    logic             w_bit;
    logic             w_sample;
    logic [2:0]       w_cntBase;
    logic [IDX_W-1:0] w_posBase;
    logic             w_complete;
    logic             w_lastByte;
    logic             w_load;
    logic             w_drop;
    logic [7:0]       w_byte;
    logic [6:0]       w_shiftNext;
    logic [2:0]       w_bitCntNext;
    logic [IDX_W-1:0] w_posNext;
    logic             w_outValidNext;

`ifdef SIPO_INVERT_EN
    assign w_bit = ~serIn;
`else
    assign w_bit = serIn;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_ARMED;
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_pos      <= '0;
            r_parOut   <= '0;
            r_outValid <= 1'b0;
            r_byteIdx  <= '0;
            r_lineDone <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shift    <= w_shiftNext;
            r_bitCnt   <= w_bitCntNext;
            r_pos      <= w_posNext;
            r_outValid <= w_outValidNext;
            r_lineDone <= w_load && w_lastByte;
            r_overflow <= r_overflow || w_drop;
            if (w_load) begin
                r_parOut  <= w_byte;
                r_byteIdx <= w_posBase;
            end
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_shiftNext    = r_shift;
        w_bitCntNext   = r_bitCnt;
        w_posNext      = r_pos;
        w_outValidNext = r_outValid;

        // lineStart rebases the counters on the same edge, so a coincident sample is bit 0
        w_cntBase  = lineStart ? 3'd0 : r_bitCnt;
        w_posBase  = lineStart ? '0 : r_pos;
        w_sample   = sampleEn && (lineStart || (r_state == ST_ARMED));
        w_complete = w_sample && (w_cntBase == 3'd7);
        w_lastByte = w_complete && (w_posBase == LAST_POS);
        w_byte     = {r_shift, w_bit};
        w_load     = w_complete && (!r_outValid || outReady);
        w_drop     = w_complete && r_outValid && !outReady;

        if (w_sample) begin
            w_shiftNext  = {r_shift[5:0], w_bit};
            w_bitCntNext = w_cntBase + 3'd1;
        end else begin
            w_bitCntNext = w_cntBase;
        end

        if (w_complete) begin
            w_posNext = w_lastByte ? '0 : (w_posBase + IDX_W'(1));
        end else begin
            w_posNext = w_posBase;
        end

        if (lineStart) begin
            w_stateNext = ST_ARMED;
        end else if (w_lastByte) begin
            w_stateNext = ST_IDLE;
        end

        if (w_load) begin
            w_outValidNext = 1'b1;
        end else if (r_outValid && outReady) begin
            w_outValidNext = 1'b0;
        end
    end

    assign parOut   = r_parOut;
    assign outValid = r_outValid;
    assign byteIdx  = r_byteIdx;
    assign lineDone = r_lineDone;
    assign overflow = r_overflow;

endmodule
